// File: rtl/dram_rowcol_receiver_if.sv
// Multiplexed DRAM address bus seen by the row/column receiver, plus the
// decoded access and refresh reports it returns.
interface dram_rowcol_receiver_if #(
  parameter int unsigned HALF_W = 8
);
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [HALF_W-1:0]     rowcol;
  logic [2*HALF_W-1:0]   addr;
  logic                  addr_valid;
  logic                  wr;
  logic                  refresh;
  logic [HALF_W-1:0]     refresh_row;
  logic                  err;

  modport master (
    output ras_n, cas_n, we_n, rowcol,
    input  addr, addr_valid, wr, refresh, refresh_row, err
  );

  modport slave (
    input  ras_n, cas_n, we_n, rowcol,
    output addr, addr_valid, wr, refresh, refresh_row, err
  );
endinterface

// File: rtl/dram_rowcol_receiver.sv
// Rebuilds {column, row} CPU addresses from a multiplexed DRAM bus and reports
// accesses, RAS-only refreshes and CAS-before-RAS refreshes as one-cycle pulses.
module dram_rowcol_receiver #(
  parameter int unsigned       HALF_W       = 8,
  parameter logic [HALF_W-1:0] REF_CNT_INIT = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  dram_rowcol_receiver_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRow, StCol, StCbr, StRelease} state_e;

  state_e                state_q, state_d;
  logic                  ras_prev_q, cas_prev_q;
  logic [HALF_W-1:0]     row_q, row_d;
  logic [HALF_W-1:0]     ref_cnt_q, ref_cnt_d;
  logic                  col_seen_q, col_seen_d;
  logic [2*HALF_W-1:0]   addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  refresh_q, refresh_d;
  logic [HALF_W-1:0]     refresh_row_q, refresh_row_d;
  logic                  err_q, err_d;

  logic ras_fall, ras_rise, cas_fall, cas_rise;

  // History resets low so strobes held low through reset never look like a fall.
  assign ras_fall = ras_prev_q & ~bus.ras_n;
  assign ras_rise = ~ras_prev_q & bus.ras_n;
  assign cas_fall = cas_prev_q & ~bus.cas_n;
  assign cas_rise = ~cas_prev_q & bus.cas_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ras_fall && cas_fall)         state_d = StRelease;
        else if (ras_fall && bus.cas_n)   state_d = StRow;
        else if (cas_fall && bus.ras_n)   state_d = StCbr;
      end
      StRow: begin
        if (ras_rise && cas_fall)         state_d = StRelease;
        else if (cas_fall)                state_d = StCol;
        else if (ras_rise)                state_d = StIdle;
      end
      StCol: begin
        if (ras_rise)                     state_d = StRelease;
        else if (cas_rise && !bus.ras_n)  state_d = StRow;
      end
      StCbr: begin
        if (ras_fall)                     state_d = StRelease;
        else if (cas_rise)                state_d = StIdle;
      end
      StRelease: begin
        if (bus.ras_n && bus.cas_n)       state_d = StIdle;
      end
      default:                            state_d = StIdle;
    endcase
  end

  always_comb begin
    row_d         = row_q;
    ref_cnt_d     = ref_cnt_q;
    col_seen_d    = col_seen_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    addr_valid_d  = 1'b0;
    refresh_d     = 1'b0;
    refresh_row_d = refresh_row_q;
    err_d         = err_q;
    unique case (state_q)
      StIdle: begin
        if (ras_fall && cas_fall) begin
          err_d = 1'b1;
        end else if (ras_fall && bus.cas_n) begin
          row_d      = bus.rowcol;
          col_seen_d = 1'b0;
        end
      end
      StRow: begin
        if (ras_rise && cas_fall) begin
          err_d = 1'b1;
        end else if (cas_fall) begin
          addr_d       = {bus.rowcol, row_q};
          wr_d         = ~bus.we_n;
          addr_valid_d = 1'b1;
          col_seen_d   = 1'b1;
        end else if (ras_rise && !col_seen_q) begin
          // RAS closed without any column strobe: a RAS-only refresh.
          refresh_d     = 1'b1;
          refresh_row_d = row_q;
        end
      end
      StCbr: begin
        if (ras_fall) begin
          refresh_d     = 1'b1;
          refresh_row_d = ref_cnt_q;
          ref_cnt_d     = ref_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_prev_q    <= 1'b0;
      cas_prev_q    <= 1'b0;
      row_q         <= '0;
      ref_cnt_q     <= REF_CNT_INIT;
      col_seen_q    <= 1'b0;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      addr_valid_q  <= 1'b0;
      refresh_q     <= 1'b0;
      refresh_row_q <= '0;
      err_q         <= 1'b0;
    end else begin
      ras_prev_q    <= bus.ras_n;
      cas_prev_q    <= bus.cas_n;
      row_q         <= row_d;
      ref_cnt_q     <= ref_cnt_d;
      col_seen_q    <= col_seen_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      addr_valid_q  <= addr_valid_d;
      refresh_q     <= refresh_d;
      refresh_row_q <= refresh_row_d;
      err_q         <= err_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.wr          = wr_q;
  assign bus.addr_valid  = addr_valid_q;
  assign bus.refresh     = refresh_q;
  assign bus.refresh_row = refresh_row_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_dram_rowcol_receiver.sv
// Directed bench for dram_rowcol_receiver: reads, page-mode writes, RAS-only
// and CBR refresh with counter wrap, aborted CBR and the sticky error flag.
module tb_dram_rowcol_receiver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   av_pulses;
  int   ref_pulses;

  dram_rowcol_receiver_if #(.HALF_W(8)) bus ();

  dram_rowcol_receiver #(
    .HALF_W       (8),
    .REF_CNT_INIT (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.addr_valid) av_pulses++;
    if (bus.refresh)    ref_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one bus sample, then let the DUT take it and settle.
  task automatic step(input logic ras, input logic cas, input logic we, input logic [7:0] rc);
    @(negedge clk);
    bus.ras_n  = ras;
    bus.cas_n  = cas;
    bus.we_n   = we;
    bus.rowcol = rc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    av_pulses  = 0;
    ref_pulses = 0;
    rst_n      = 1'b0;
    bus.ras_n  = 1'b0;
    bus.cas_n  = 1'b0;
    bus.we_n   = 1'b1;
    bus.rowcol = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr", 32'(bus.addr), 32'h0);
    check_eq("rst_valid", 32'(bus.addr_valid), 32'h0);
    check_eq("rst_wr", 32'(bus.wr), 32'h0);
    check_eq("rst_refresh", 32'(bus.refresh), 32'h0);
    check_eq("rst_refresh_row", 32'(bus.refresh_row), 32'h0);
    check_eq("rst_err", 32'(bus.err), 32'h0);

    // Release reset with both strobes low, then raise them.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("post_rst_av_pulses", 32'(av_pulses), 32'd0);
    check_eq("post_rst_ref_pulses", 32'(ref_pulses), 32'd0);
    check_eq("post_rst_err", 32'(bus.err), 32'h0);

    // Read of 0x0F5A.
    av_pulses = 0;
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    check_eq("rd_no_early_valid", 32'(bus.addr_valid), 32'h0);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h0F);
    check_eq("rd_valid", 32'(bus.addr_valid), 32'h1);
    check_eq("rd_addr", 32'(bus.addr), 32'h0F5A);
    check_eq("rd_wr", 32'(bus.wr), 32'h0);
    step(1'b0, 1'b0, 1'b1, 8'h33);
    check_eq("rd_valid_drop", 32'(bus.addr_valid), 32'h0);
    check_eq("rd_addr_hold", 32'(bus.addr), 32'h0F5A);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("rd_pulse_count", 32'(av_pulses), 32'd1);

    // Page-mode write: row 0x34, columns 0x12 then 0xAB.
    av_pulses = 0;
    step(1'b0, 1'b1, 1'b0, 8'h34);
    step(1'b0, 1'b0, 1'b0, 8'h12);
    check_eq("pg1_addr", 32'(bus.addr), 32'h1234);
    check_eq("pg1_wr", 32'(bus.wr), 32'h1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'hAB);
    check_eq("pg2_valid", 32'(bus.addr_valid), 32'h1);
    check_eq("pg2_addr", 32'(bus.addr), 32'hAB34);
    check_eq("pg2_wr", 32'(bus.wr), 32'h1);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("pg_pulse_count", 32'(av_pulses), 32'd2);
    check_eq("pg_no_refresh", 32'(ref_pulses), 32'd0);

    // RAS-only refresh of row 0x7E.
    av_pulses = 0;
    step(1'b0, 1'b1, 1'b1, 8'h7E);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("ror_refresh", 32'(bus.refresh), 32'h1);
    check_eq("ror_row", 32'(bus.refresh_row), 32'h7E);
    check_eq("ror_no_valid", 32'(bus.addr_valid), 32'h0);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("ror_refresh_drop", 32'(bus.refresh), 32'h0);
    check_eq("ror_av_pulses", 32'(av_pulses), 32'd0);

    // 257 CBR cycles: counter runs 0x00..0xFF then wraps to 0x00.
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check_eq($sformatf("cbr_row_%0d", i), 32'(bus.refresh_row), 32'(i % 256));
      check_eq($sformatf("cbr_pulse_%0d", i), 32'(bus.refresh), 32'h1);
      step(1'b1, 1'b1, 1'b1, 8'h00);
    end

    // Aborted CBR: cas rises before ras falls.
    ref_pulses = 0;
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("cbr_abort_no_refresh", 32'(ref_pulses), 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("cbr_after_abort_row", 32'(bus.refresh_row), 32'h01);
    step(1'b1, 1'b1, 1'b1, 8'h00);

    // Simultaneous ras/cas fall from idle sets the sticky error.
    check_eq("err_before", 32'(bus.err), 32'h0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("err_set", 32'(bus.err), 32'h1);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 1'b1, 8'h96);
    check_eq("err_access_addr", 32'(bus.addr), 32'h96C3);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check_eq("err_sticky", 32'(bus.err), 32'h1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("err_clear_by_reset", 32'(bus.err), 32'h0);
    check_eq("addr_clear_by_reset", 32'(bus.addr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
